// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// Optional error-flag feature is selected by the FIFO_ERR_EN macro.
package fifo_pkg;

    // Status bundle consumed by downstream arbiters
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Advance a pointer, wrapping at depth-1 for any depth
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Handshake/status bundle between a FIFO user (master) and fifo_sync_ctrl (slave).
// Error ports exist only when FIFO_ERR_EN is defined.
interface fifo_sync_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256
);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic              flush;
    logic              push;
    logic [DATA_W-1:0] wr_data;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
`ifdef FIFO_ERR_EN
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport master (
        output flush, push, wr_data, pop, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
    modport slave (
        input  flush, push, wr_data, pop, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
`else
    modport master (
        output flush, push, wr_data, pop,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count
    );
    modport slave (
        input  flush, push, wr_data, pop,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count
    );
`endif
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port (block-RAM style).
// Read of an address being written in the same cycle returns the old word.
module fifo_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Output register uses the block-RAM output-register sync reset
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO for the Z-buffer datapath: any depth, occupancy count, threshold flags, flush.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic       clk,
    input  logic       reset,
    fifo_sync_ctrl_if.slave fifo
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    fifo_status_t  status_q;
    logic          rd_valid_q;

    logic          pop_ok_c, push_ok_c;
    logic [CW-1:0] count_next_c;

    always_comb begin
        pop_ok_c     = fifo.pop & ~status_q.empty;
        push_ok_c    = fifo.push & (~status_q.full | pop_ok_c);
        count_next_c = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end

    // Pointers, count and flags; flags come from count_next so they track count
    always_ff @(posedge clk) begin
        if (reset || fifo.flush) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count_q               <= '0;
            status_q.full         <= 1'b0;
            status_q.empty        <= 1'b1;
            status_q.almost_full  <= 1'b0;
            status_q.almost_empty <= 1'b1;
            rd_valid_q            <= 1'b0;
        end else begin
            if (push_ok_c)
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (pop_ok_c)
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            count_q               <= count_next_c;
            status_q.full         <= (count_next_c == CW'(DEPTH));
            status_q.empty        <= (count_next_c == '0);
            status_q.almost_full  <= (count_next_c >= CW'(AF_LEVEL));
            status_q.almost_empty <= (count_next_c <= CW'(AE_LEVEL));
            rd_valid_q            <= pop_ok_c;
        end
    end

    // Flush holds rd_data, so the read port is gated by it; reset clears it inside the RAM
    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok_c & ~fifo.flush & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (fifo.wr_data),
        .rd_en   (pop_ok_c & ~fifo.flush),
        .rd_addr (rd_ptr),
        .rd_data (fifo.rd_data)
    );

    assign fifo.rd_valid     = rd_valid_q;
    assign fifo.count        = count_q;
    assign fifo.full         = status_q.full;
    assign fifo.empty        = status_q.empty;
    assign fifo.almost_full  = status_q.almost_full;
    assign fifo.almost_empty = status_q.almost_empty;

`ifdef FIFO_ERR_EN
    logic overflow_q, underflow_q;
    logic ovf_set_c, unf_set_c;

    always_comb begin
        ovf_set_c = fifo.push & status_q.full & ~pop_ok_c;
        unf_set_c = fifo.pop & status_q.empty;
    end

    // Sticky error flags; a new error wins over a coincident err_clr
    always_ff @(posedge clk) begin
        if (reset || fifo.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_set_c | (overflow_q  & ~fifo.err_clr);
            underflow_q <= unf_set_c | (underflow_q & ~fifo.err_clr);
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
// Error-flag checks are included when FIFO_ERR_EN is defined.
module tb_fifo_sync_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_sync_ctrl_if #(.DATA_W(16), .DEPTH(5)) bus ();

    fifo_sync_ctrl #(
        .DATA_W   (16),
        .DEPTH    (5),
        .AF_LEVEL (4),
        .AE_LEVEL (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
`ifdef FIFO_ERR_EN
        bus.err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle();
        bus.wr_data = 16'h0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", bus.almost_empty); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", bus.rd_data); end
        n_checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full_af got %b%b want 00", bus.full, bus.almost_full); end
`ifdef FIFO_ERR_EN
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", bus.overflow, bus.underflow); end
`endif
    endtask

    // Push 0x11..0x16; also covers almost_empty/almost_full thresholds on the way up
    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            int exp_cnt;
            exp_cnt = (i < 5) ? i : 5;
            bus.push    = 1'b1;
            bus.wr_data = 16'(16'h10 + i);
            step();
            n_checks++; if (bus.count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count, exp_cnt); end
            n_checks++; if (bus.full !== (exp_cnt == 5)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, bus.full, exp_cnt == 5); end
            n_checks++; if (bus.almost_full !== (exp_cnt >= 4)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, bus.almost_full, exp_cnt >= 4); end
            n_checks++; if (bus.almost_empty !== (exp_cnt <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, bus.almost_empty, exp_cnt <= 1); end
            n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b want 0", i, bus.empty); end
        end
        idle();
`ifdef FIFO_ERR_EN
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %b want 1", bus.overflow); end
        step();
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b want 1", bus.overflow); end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clr got %b want 0", bus.overflow); end
`endif
    endtask

    task automatic test_drain();
        for (int j = 1; j <= 5; j++) begin
            int exp_cnt;
            exp_cnt  = 5 - j;
            bus.pop  = 1'b1;
            step();
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got %b want 1", j, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== 16'(16'h10 + j)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", j, bus.rd_data, 16'(16'h10 + j)); end
            n_checks++; if (bus.count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", j, bus.count, exp_cnt); end
            n_checks++; if (bus.almost_full !== (exp_cnt >= 4)) begin n_fail++; $display("FAIL drain_af[%0d] got %b want %b", j, bus.almost_full, exp_cnt >= 4); end
            n_checks++; if (bus.almost_empty !== (exp_cnt <= 1)) begin n_fail++; $display("FAIL drain_ae[%0d] got %b want %b", j, bus.almost_empty, exp_cnt <= 1); end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", bus.empty); end
        step();
        idle();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL extra_pop_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 16'h0015) begin n_fail++; $display("FAIL extra_pop_hold got %h want 0015", bus.rd_data); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL extra_pop_count got %0d want 0", bus.count); end
`ifdef FIFO_ERR_EN
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set got %b want 1", bus.underflow); end
        bus.err_clr = 1'b1;
        bus.pop     = 1'b1;
        step();
        idle();
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_clr_vs_set got %b want 1", bus.underflow); end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clr got %b want 0", bus.underflow); end
`endif
        // Streaming push/pop of 0x21..0x27 across the 4->0 pointer wrap
        for (int i = 0; i <= 7; i++) begin
            int exp_cnt;
            exp_cnt     = (i < 7) ? 1 : 0;
            bus.push    = (i < 7);
            bus.wr_data = 16'(16'h21 + i);
            bus.pop     = (i > 0);
            step();
            n_checks++; if (bus.count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, bus.count, exp_cnt); end
            if (i > 0) begin
                n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'(16'h20 + i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %b/%h want 1/%h", i, bus.rd_valid, bus.rd_data, 16'(16'h20 + i)); end
            end
        end
        idle();
    endtask

    // Pointers now sit at index 2; exercises full+push+pop (same-address read) and empty+push+pop
    task automatic test_simultaneous();
        logic [15:0] exp_words [5];
        exp_words[0] = 16'h0032; exp_words[1] = 16'h0033; exp_words[2] = 16'h0034;
        exp_words[3] = 16'h0035; exp_words[4] = 16'h00AA;
        for (int i = 0; i < 5; i++) begin
            bus.push    = 1'b1;
            bus.wr_data = 16'(16'h31 + i);
            step();
        end
        bus.wr_data = 16'h00AA;
        bus.pop     = 1'b1;
        step();
        idle();
        n_checks++; if (bus.count !== 3'd5 || bus.full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_count got %0d/%b want 5/1", bus.count, bus.full); end
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0031) begin n_fail++; $display("FAIL full_pushpop_data got %b/%h want 1/0031", bus.rd_valid, bus.rd_data); end
`ifdef FIFO_ERR_EN
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf got %b want 0", bus.overflow); end
`endif
        for (int i = 0; i < 5; i++) begin
            bus.pop = 1'b1;
            step();
            n_checks++; if (bus.rd_data !== exp_words[i]) begin n_fail++; $display("FAIL full_pushpop_order[%0d] got %h want %h", i, bus.rd_data, exp_words[i]); end
        end
        idle();
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.wr_data = 16'h00BB;
        step();
        idle();
        n_checks++; if (bus.count !== 3'd1 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop_count got %0d/%b want 1/0", bus.count, bus.empty); end
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h00AA) begin n_fail++; $display("FAIL empty_pushpop_rd got %b/%h want 0/00aa", bus.rd_valid, bus.rd_data); end
        bus.pop = 1'b1;
        step();
        idle();
        n_checks++; if (bus.rd_data !== 16'h00BB || bus.count !== 3'd0) begin n_fail++; $display("FAIL empty_pushpop_bb got %h/%0d want 00bb/0", bus.rd_data, bus.count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            bus.push    = 1'b1;
            bus.wr_data = 16'(16'h41 + i);
            step();
        end
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", bus.count); end
        bus.flush   = 1'b1;
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.wr_data = 16'h0099;
        step();
        idle();
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL flush_count got %0d/%b want 0/1", bus.count, bus.empty); end
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h00BB) begin n_fail++; $display("FAIL flush_rd got %b/%h want 0/00bb", bus.rd_valid, bus.rd_data); end
        n_checks++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_flags got %b%b want 10", bus.almost_empty, bus.almost_full); end
        bus.push    = 1'b1;
        bus.wr_data = 16'h005A;
        step();
        idle();
        bus.pop = 1'b1;
        step();
        idle();
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h005A) begin n_fail++; $display("FAIL flush_after got %b/%h want 1/005a", bus.rd_valid, bus.rd_data); end
        step();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_reset_traffic();
        bus.push    = 1'b1;
        bus.wr_data = 16'h0077;
        step();
        step();
        bus.pop = 1'b1;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        idle();
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_traffic_count got %0d/%b want 0/1", bus.count, bus.empty); end
        n_checks++; if (bus.rd_data !== 16'h0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_traffic_rd got %h/%b want 0000/0", bus.rd_data, bus.rd_valid); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_flush();
        test_reset_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_sync_ctrl.md
# fifo_sync_ctrl

Parametrised synchronous FIFO with its storage array, the next generation of the single-port FIFO controller in the Z-buffer datapath. It buffers fragment/depth words between pipeline stages and accepts a push and a pop in the same cycle. Depth can be any value, not only a power of two, and width is set by parameter. It adds almost-full/almost-empty levels, a synchronous flush and an occupancy count.

## Interface
- DATA_W, 16, word width in bits
- DEPTH, 256, number of entries; ≥2, any integer
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL; range 0..DEPTH-1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all contents
- push  in  1  write request
- wr_data  in  DATA_W  write word
- pop  in  1  read request
- rd_data  out  DATA_W  read word, registered
- rd_valid  out  1  rd_data holds the word popped in the previous cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  occupancy, CW = $clog2(DEPTH+1)

## Operation
- State: wr_ptr and rd_ptr, each PW = $clog2(DEPTH) bits, plus count. Each pointer increments and wraps from DEPTH-1 to 0, without relying on power-of-two overflow.
- Reset values: pointers 0, count 0, full 0, empty 1, almost_full 0, almost_empty 1, rd_valid 0, rd_data 0. Memory contents are not reset.
- Acceptance, evaluated each cycle:
  - pop_ok = pop & !empty
  - push_ok = push & (!full | pop_ok)
- Full with push and pop together: both are accepted and count is unchanged.
- Empty with push and pop together: the push is accepted, the pop is ignored, and count becomes 1.
- Rejected push (full, no pop) or rejected pop (empty): no state change, and the word is dropped.
- Count update: count_next = count + push_ok - pop_ok. Flags are registered and derived from count_next, so they are valid in the same cycle as count.
- Write: on push_ok, mem[wr_ptr] ← wr_data, and wr_ptr advances.
- Read: on pop_ok, rd_data ← mem[rd_ptr] and rd_ptr advances. rd_valid is 1 in the next cycle and 0 otherwise. rd_data holds its last value when no pop occurs.
- Read/write on the same address (only possible when a push and pop share an entry while full): the read returns the old stored word.
- Flush has priority over push and pop. Pointers and count go to 0, and flags take their reset values on the next edge. rd_valid goes to 0, any push in the flush cycle is discarded, and rd_data is held.
- Reset during traffic: same effect as flush, and in addition rd_data clears to 0.

## Timing
- Push to visible: count and empty update one cycle after a push_ok edge. The earliest pop of that word is in the cycle after the push.
- Pop latency: rd_data and rd_valid are valid one cycle after the pop_ok cycle.
- Throughput: one push and one pop per cycle, sustained indefinitely, when neither full nor empty.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FIFO_ERR_EN compiled in:
  - Adds ports: overflow out 1, underflow out 1, err_clr in 1.
  - overflow becomes sticky 1 in the cycle after a push is rejected by the full condition.
  - underflow becomes sticky 1 in the cycle after a pop occurs while empty.
  - Both flags clear on err_clr, reset or flush. If err_clr and a new error coincide, the flag is set.
- FIFO_ERR_EN absent: the ports do not exist, rejected requests are silently dropped, and all other behaviour is identical.

## Structure
- Package fifo_pkg holds:
  - a function for pointer increment with wrap at DEPTH-1
  - a function for counter width (clog2 of DEPTH+1)
  - a shared fifo_status_t struct {full, empty, almost_full, almost_empty}, used by downstream arbiters
- One sub-module, fifo_ram: a simple dual-port array with one write port and one registered read port, parameters DATA_W and DEPTH. It is written so it infers block RAM on the FPGA.
- Controller logic (pointers, count, flags, error flags) lives in fifo_sync_ctrl.

## Test plan
- **Reset then idle:** assert reset for 2 cycles → empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0.
- **Fill and overrun:** DEPTH=5, push 6 words 0x11..0x16 back-to-back → full=1 after the 5th, count=5, 6th dropped. With FIFO_ERR_EN, overflow=1 one cycle after the 6th push.
- **Drain with wrap:** from the fill test, pop 5 words then 1 extra → rd_data 0x11..0x15 each one cycle after its pop, empty=1, extra pop gives no rd_valid. With FIFO_ERR_EN, underflow=1. Then push and pop 7 more words → order preserved across the pointer wrap at index 4→0.
- **Simultaneous events:**
  - When full, push 0xAA with pop → count stays 5, rd_data = oldest word, 0xAA is stored last.
  - When empty, push 0xBB with pop → count=1, rd_valid=0.
- **Threshold flags:** AF_LEVEL=4, AE_LEVEL=1 → almost_empty stays 1 at counts 0–1 and drops at 2; almost_full rises at count 4 and falls when count returns to 3.
- **Flush mid-stream:** with count=3, assert flush together with push and pop → next cycle count=0, empty=1, rd_valid=0. A following push of 0x5A then a pop → rd_data=0x5A.
